spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (sclk, pico, poci, cs lines) among NUM_REQUESTERS SPI masters, e.g. the MCU's SPI controller and a hardware flash loader.
- Round-robin arbitration; the grant is held for a whole transaction, until the requester drops req.
- Sits between the SPI masters and the board pins in the board top.
- Guarantees cs deasserted, sclk idle, and a programmable idle gap on every ownership change.

Parameters:
- NUM_REQUESTERS, 2, number of SPI masters sharing the bus (2..8).
- NUM_CS_LINES, 1, chip-select lines per master; cs is active-low.
- SCLK_IDLE, 1'b0, sclk level driven while no owner (CPOL).
- GAP_CYCLES, 2, idle cycles forced between release and the next grant (0..255).
- TIMEOUT_CYCLES, 65536, grant watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQUESTERS  bus request, one bit per master, level-held for the whole transaction.
- gnt  out  NUM_REQUESTERS  one-hot (or zero) grant.
- m_sclk  in  NUM_REQUESTERS  per-master sclk.
- m_pico  in  NUM_REQUESTERS  per-master pico.
- m_cs  in  NUM_REQUESTERS*NUM_CS_LINES  per-master cs; master i uses bits [i*NUM_CS_LINES +: NUM_CS_LINES].
- m_poci  out  NUM_REQUESTERS  poci returned to each master.
- sclk  out  1  physical bus clock.
- pico  out  1  physical bus data out.
- poci  in  1  physical bus data in.
- cs  out  NUM_CS_LINES  physical chip selects.
- timeout  out  1  one-cycle pulse on watchdog revoke; tied 0 when the feature is absent.

Behaviour:
- Reset values: gnt=0, sclk=SCLK_IDLE, pico=0, cs=all 1s, timeout=0, state=IDLE, round-robin pointer=0 (requester 0 highest priority).
- Reset asserted mid-transaction drops gnt and forces bus idle on the next edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Pick the first set req, scanning from the pointer upward with wrap-around.
  - Register gnt[k]=1 and go to GRANT; gnt rises 1 cycle after req is sampled.
  - Set pointer = k+1 mod NUM_REQUESTERS.
  - No req: stay in IDLE.
- GRANT:
  - Outputs sclk/pico/cs are registered copies of master k's signals, 1-cycle latency. Masters start toggling only after they observe gnt.
  - m_poci[k]=poci (combinational); all other m_poci bits=0.
  - Other requests are ignored; there is no preemption.
- Release:
  - req[k] sampled low in GRANT: gnt=0 and pins forced idle (cs all 1s, sclk=SCLK_IDLE, pico=0) on the same edge.
  - Go to GAP; go directly to IDLE if GAP_CYCLES=0.
- GAP:
  - Counter counts GAP_CYCLES cycles with bus idle, then go to IDLE.
  - Requests asserted during GAP wait; they are evaluated in IDLE.
- Bus timing:
  - Minimum cycles from release sample to next gnt: GAP_CYCLES+1 (IDLE evaluation cycle included).
  - Physical cs always shows ≥ GAP_CYCLES+1 cycles high between owners.
- Simultaneous requests: round-robin order only. With req=all 1s continuously, grants rotate 0,1,…,N-1,0.
- req of an ungranted master dropping before grant: withdrawn, no effect.
- gnt is never multi-hot. Pins never mix two masters' signals.

Optional Feature:
- Macro: SPI_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs in GRANT. When the grant has lasted TIMEOUT_CYCLES cycles, gnt is dropped and the bus forced idle.
  - timeout pulses high for 1 cycle, and the arbiter enters GAP.
  - The revoked master is ineligible until its req has been sampled low at least once; its stale req is never re-granted.
- Undefined: no counter; timeout tied 0; grant held indefinitely.

Test Plan:
- Reset then idle: req=0 for 20 cycles -> gnt=0, cs=1, sclk=SCLK_IDLE, pico=0 throughout.
- Single master: req=01 at cycle 10 -> gnt=01 at cycle 11. m_cs0 toggled 1→0 -> cs goes 0 one cycle later. m_poci[0] follows poci; m_poci[1]=0.
- Contention with GAP_CYCLES=2: req=11 held, master 0 releases at cycle 30 -> gnt=00 at 31, cs=1 for cycles 31–33, gnt=10 at cycle 34.
- Fairness: req=11 continuously, each master releases after 5 cycles of grant and immediately re-requests -> grant order 0,1,0,1; no master granted twice in a row.
- Reset mid-transaction: reset=1 for 1 cycle while gnt=01 and cs=0 -> next cycle gnt=0, cs=1, pointer=0. With req=11 after reset, master 0 wins.
- Timeout with feature enabled, TIMEOUT_CYCLES=16: master 0 holds req -> 16 cycles after gnt, gnt=0 and timeout=1 for one cycle. Master 1 is granted after the gap. Master 0 is not re-granted until it toggles req low then high.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner-of-bus arbiter for several SPI masters sharing one set of pins.
// Optional grant watchdog: define SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter #(
   parameter int   NUM_REQUESTERS = 2,
   parameter int   NUM_CS_LINES   = 1,
   parameter logic SCLK_IDLE      = 1'b0,
   parameter int   GAP_CYCLES     = 2,
   parameter int   TIMEOUT_CYCLES = 65536
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_REQUESTERS-1:0]              req,
   output logic [NUM_REQUESTERS-1:0]              gnt,
   input  logic [NUM_REQUESTERS-1:0]              m_sclk,
   input  logic [NUM_REQUESTERS-1:0]              m_pico,
   input  logic [NUM_REQUESTERS*NUM_CS_LINES-1:0] m_cs,
   output logic [NUM_REQUESTERS-1:0]              m_poci,
   output logic                                   sclk,
   output logic                                   pico,
   input  logic                                   poci,
   output logic [NUM_CS_LINES-1:0]                cs,
   output logic                                   timeout
);

   localparam int N  = NUM_REQUESTERS;
   localparam int PW = $clog2(N);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t        state;
   logic [PW-1:0] ptr, owner, pick;
   logic          found;
   logic [7:0]    gap_cnt;
   logic [N-1:0]  elig;
   logic          revoke;
   logic          release_now;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic [N-1:0]  blocked;

   // A revoked master stays blocked until its req is seen low once.
   assign elig   = req & ~blocked;
   assign revoke = (state == GRANT) && req[owner] && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
         blocked <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= revoke;
         blocked <= (blocked & req) | (revoke ? (ONE << owner) : '0);
         tmo_cnt <= (state == GRANT && !revoke) ? tmo_cnt + 1'b1 : '0;
      end
   end
`else
   assign elig    = req;
   assign revoke  = 1'b0;
   assign timeout = 1'b0;
`endif

   assign release_now = (state == GRANT) && (!req[owner] || revoke);

   // First eligible requester at or after the pointer, with wrap-around.
   always_comb begin
      logic [PW-1:0] idx;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= '0;
         ptr     <= '0;
         owner   <= '0;
         gap_cnt <= '0;
         sclk    <= SCLK_IDLE;
         pico    <= 1'b0;
         cs      <= '1;
      end else begin
         // Pins idle unless a live owner overrides below.
         sclk <= SCLK_IDLE;
         pico <= 1'b0;
         cs   <= '1;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt   <= ONE << pick;
                  owner <= pick;
                  ptr   <= (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt     <= '0;
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  sclk <= m_sclk[owner];
                  pico <= m_pico[owner];
                  cs   <= m_cs[owner*NUM_CS_LINES +: NUM_CS_LINES];
               end
            end
            GAP: begin
               if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= IDLE;
               else                               gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // gnt is one-hot only while in GRANT, so it doubles as the poci return mask.
   for (genvar i = 0; i < N; i++) begin : g_poci
      assign m_poci[i] = gnt[i] & poci;
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: 2 masters, 1 cs line, GAP_CYCLES=2, TIMEOUT_CYCLES=16.
module tb_spi_bus_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] req, gnt, m_sclk, m_pico, m_cs, m_poci;
   logic       sclk, pico, poci, timeout;
   logic [0:0] cs;

   int vectors    = 0;
   int miscompares = 0;
   logic [1:0] exp_q[$];

   spi_bus_arbiter #(
      .NUM_REQUESTERS(2), .NUM_CS_LINES(1), .SCLK_IDLE(1'b0),
      .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .gnt(gnt),
      .m_sclk(m_sclk), .m_pico(m_pico), .m_cs(m_cs), .m_poci(m_poci),
      .sclk(sclk), .pico(pico), .poci(poci), .cs(cs), .timeout(timeout)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   always @(negedge clock) begin
      if (reset === 1'b0) begin
         vectors++;
         if (!$onehot0(gnt)) begin
            miscompares++;
            $display("FAIL gnt_onehot got=%b required=one-hot or zero", gnt);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_masters();
      m_sclk = 2'b00; m_pico = 2'b00; m_cs = 2'b11; poci = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1; req = 2'b00; idle_masters();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_gnt(output logic [1:0] g, output int n);
      n = 0;
      while (gnt == 2'b00 && n < 60) begin
         tick();
         n++;
      end
      g = gnt;
   endtask

   task automatic test_reset();
      logic bad;
      reset = 1'b1; req = 2'b00; idle_masters();
      tick(); tick();
      reset = 1'b0;
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
      vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL reset_cs got=%b exp=1", cs); end
      vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
      vectors++; if (pico !== 1'b0) begin miscompares++; $display("FAIL reset_pico got=%b exp=0", pico); end
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         m_sclk = 2'($urandom); m_pico = 2'($urandom); m_cs = 2'($urandom);
         tick();
         if (gnt !== 2'b00 || cs !== 1'b1 || sclk !== 1'b0 || pico !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin miscompares++; $display("FAIL idle_pins got=gnt %b cs %b sclk %b pico %b exp=idle", gnt, cs, sclk, pico); end
      idle_masters();
   endtask

   task automatic test_single();
      logic [1:0] e;
      apply_reset();
      req = 2'b01; exp_q.push_back(2'b01);
      tick();
      e = exp_q.pop_front();
      vectors++; if (gnt !== e) begin miscompares++; $display("FAIL single_gnt got=%b exp=%b", gnt, e); end
      vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL single_cs_first got=%b exp=1", cs); end
      m_cs = 2'b00; m_sclk = 2'b01; m_pico = 2'b01;
      tick();
      vectors++; if ({cs, sclk, pico} !== 3'b011) begin miscompares++; $display("FAIL single_pins got=%b exp=011", {cs, sclk, pico}); end
      m_pico = 2'b10;
      tick();
      vectors++; if (pico !== 1'b0) begin miscompares++; $display("FAIL single_pico_owner got=%b exp=0", pico); end
      poci = 1'b1; #1;
      vectors++; if (m_poci !== 2'b01) begin miscompares++; $display("FAIL single_poci_hi got=%b exp=01", m_poci); end
      poci = 1'b0; #1;
      vectors++; if (m_poci !== 2'b00) begin miscompares++; $display("FAIL single_poci_lo got=%b exp=00", m_poci); end
      m_pico = 2'b01; req = 2'b00;
      tick();
      vectors++; if ({gnt, cs, sclk, pico} !== 5'b00100) begin miscompares++; $display("FAIL single_release got=%b exp=00100", {gnt, cs, sclk, pico}); end
      idle_masters();
      tick(); tick();
   endtask

   task automatic test_contention();
      logic [1:0] e;
      logic bad;
      apply_reset();
      m_cs = 2'b01; m_sclk = 2'b10;
      req = 2'b11; exp_q.push_back(2'b01);
      tick();
      e = exp_q.pop_front();
      vectors++; if (gnt !== e) begin miscompares++; $display("FAIL cont_first got=%b exp=%b", gnt, e); end
      m_cs = 2'b00;
      repeat (3) tick();
      vectors++; if (cs !== 1'b0) begin miscompares++; $display("FAIL cont_cs_owned got=%b exp=0", cs); end
      req = 2'b10; m_cs = 2'b01; exp_q.push_back(2'b10);
      tick();
      vectors++; if ({gnt, cs, sclk} !== 4'b0010) begin miscompares++; $display("FAIL cont_release got=%b exp=0010", {gnt, cs, sclk}); end
      bad = 1'b0;
      repeat (2) begin
         tick();
         if (gnt !== 2'b00 || cs !== 1'b1) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL cont_gap got=gnt %b cs %b exp=00 1", gnt, cs); end
      tick();
      e = exp_q.pop_front();
      vectors++; if (gnt !== e) begin miscompares++; $display("FAIL cont_second got=%b exp=%b", gnt, e); end
      vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL cont_cs_third_gap got=%b exp=1", cs); end
      tick();
      vectors++; if ({cs, sclk} !== 2'b01) begin miscompares++; $display("FAIL cont_owner1_pins got=%b exp=01", {cs, sclk}); end
      req = 2'b00;
      tick();
      idle_masters();
      repeat (3) tick();
   endtask

   task automatic test_fairness();
      logic [1:0] g, e, last;
      int n;
      apply_reset();
      req = 2'b11;
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      last = 2'b00;
      for (int r = 0; r < 4; r++) begin
         wait_gnt(g, n);
         e = exp_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("FAIL fair_order round %0d got=%b exp=%b wait=%0d", r, g, e, n); end
         vectors++; if (g === last) begin miscompares++; $display("FAIL fair_repeat round %0d got=%b exp=not %b", r, g, last); end
         last = g;
         repeat (5) tick();
         req = req & ~g;
         tick();
         req = 2'b11;
      end
      req = 2'b00;
      repeat (6) tick();
   endtask

   task automatic test_reset_mid();
      logic [1:0] e;
      apply_reset();
      req = 2'b01;
      tick();
      m_cs = 2'b10;
      tick(); tick();
      vectors++; if ({gnt, cs} !== 3'b010) begin miscompares++; $display("FAIL mid_pre got=%b exp=010", {gnt, cs}); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if ({gnt, cs} !== 3'b001) begin miscompares++; $display("FAIL mid_reset got=%b exp=001", {gnt, cs}); end
      req = 2'b11; exp_q.push_back(2'b01);
      tick();
      e = exp_q.pop_front();
      vectors++; if (gnt !== e) begin miscompares++; $display("FAIL mid_ptr got=%b exp=%b", gnt, e); end
      req = 2'b00; idle_masters();
      repeat (4) tick();
   endtask

   task automatic test_withdraw();
      logic bad;
      apply_reset();
      req = 2'b11;
      tick();
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL wd_gnt got=%b exp=01", gnt); end
      req = 2'b01;
      repeat (3) tick();
      req = 2'b00;
      tick();
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (gnt !== 2'b00) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL wd_no_grant got=%b exp=00", gnt); end
   endtask

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
   task automatic test_timeout();
      logic [1:0] g, e;
      logic bad;
      int n;
      apply_reset();
      req = 2'b01; exp_q.push_back(2'b01);
      tick();
      e = exp_q.pop_front();
      vectors++; if ({gnt, timeout} !== {e, 1'b0}) begin miscompares++; $display("FAIL tmo_grant got=%b exp=%b", {gnt, timeout}, {e, 1'b0}); end
      req = 2'b11;
      bad = 1'b0;
      repeat (15) begin
         tick();
         if (gnt !== 2'b01 || timeout !== 1'b0) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL tmo_early got=gnt %b timeout %b exp=01 0", gnt, timeout); end
      tick();
      vectors++; if ({gnt, timeout, cs} !== 4'b0011) begin miscompares++; $display("FAIL tmo_revoke got=%b exp=0011", {gnt, timeout, cs}); end
      tick();
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse got=%b exp=0", timeout); end
      exp_q.push_back(2'b10);
      wait_gnt(g, n);
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL tmo_next got=%b exp=%b", g, e); end
      vectors++; if (n !== 2) begin miscompares++; $display("FAIL tmo_gap got=%0d cycles exp=2", n); end
      req = 2'b01;
      bad = 1'b0;
      repeat (12) begin
         tick();
         if (gnt !== 2'b00) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL tmo_stale got=%b exp=00", gnt); end
      req = 2'b00;
      tick();
      req = 2'b01; exp_q.push_back(2'b01);
      wait_gnt(g, n);
      e = exp_q.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL tmo_regrant got=%b exp=%b", g, e); end
      req = 2'b00;
      repeat (4) tick();
   endtask
`else
   task automatic test_no_timeout();
      logic bad;
      apply_reset();
      req = 2'b01;
      tick();
      bad = 1'b0;
      repeat (40) begin
         tick();
         if (gnt !== 2'b01 || timeout !== 1'b0) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL hold_grant got=gnt %b timeout %b exp=01 0", gnt, timeout); end
      req = 2'b00;
      repeat (4) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_reset_mid();
      test_withdraw();
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
